// File: rtl/mem_2r1w_port_arbiter.sv
// Arbitrates a core (read/masked-write) and a snoop (read-only) requester onto a 2R1W memory macro.
// Latency: grant is same-cycle combinational; read data appears on rsp_data_o one cycle after grant.
// Backpressure: each port owns one response slot; a read is only granted when that slot is free or being consumed.
module mem_2r1w_port_arbiter #(
    parameter int width_p        = 32,
    parameter int els_p          = 64,
    parameter int starve_limit_p = 4,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int cnt_width_lp  = $clog2(starve_limit_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     nreset_i,

    input  logic                     core_v_i,
    input  logic                     core_w_i,
    input  logic [addr_width_lp-1:0] core_addr_i,
    input  logic [width_p-1:0]       core_mask_i,
    input  logic [width_p-1:0]       core_data_i,
    output logic                     core_ready_o,
    output logic                     core_rsp_v_o,
    output logic [width_p-1:0]       core_rsp_data_o,
    input  logic                     core_rsp_yumi_i,

    input  logic                     snoop_v_i,
    input  logic [addr_width_lp-1:0] snoop_addr_i,
    output logic                     snoop_ready_o,
    output logic                     snoop_rsp_v_o,
    output logic [width_p-1:0]       snoop_rsp_data_o,
    input  logic                     snoop_rsp_yumi_i,

    output logic                     mem_a_v_o,
    output logic                     mem_a_w_o,
    output logic [addr_width_lp-1:0] mem_a_addr_o,
    output logic [width_p-1:0]       mem_a_mask_o,
    output logic [width_p-1:0]       mem_a_data_o,
    input  logic [width_p-1:0]       mem_a_data_i,

    output logic                     mem_b_v_o,
    output logic [addr_width_lp-1:0] mem_b_addr_o,
    input  logic [width_p-1:0]       mem_b_data_i
);

    logic                    w_cw;
    logic                    w_core_slot_free;
    logic                    w_snoop_slot_free;
    logic                    w_core_ok;
    logic                    w_snoop_ok;
    logic                    w_starved;
    logic                    w_core_gnt;
    logic                    w_snoop_gnt;

    logic [cnt_width_lp-1:0] r_starve_cnt;

    // r_*_pend: read granted last cycle, data is live on the macro output now.
    // r_*_hold_v: response was not consumed on arrival and now lives in r_*_hold.
    logic                    r_core_pend;
    logic                    r_core_hold_v;
    logic [width_p-1:0]      r_core_hold;
    logic                    r_snoop_pend;
    logic                    r_snoop_hold_v;
    logic [width_p-1:0]      r_snoop_hold;

    // Responses are suppressed while reset is asserted so an in-flight read never surfaces.
    assign core_rsp_v_o     = nreset_i & (r_core_pend | r_core_hold_v);
    assign core_rsp_data_o  = r_core_hold_v ? r_core_hold : mem_a_data_i;
    assign snoop_rsp_v_o    = nreset_i & (r_snoop_pend | r_snoop_hold_v);
    assign snoop_rsp_data_o = r_snoop_hold_v ? r_snoop_hold : mem_b_data_i;

    assign w_cw              = core_v_i & core_w_i;
    assign w_core_slot_free  = ~core_rsp_v_o | core_rsp_yumi_i;
    assign w_snoop_slot_free = ~snoop_rsp_v_o | snoop_rsp_yumi_i;
    assign w_core_ok         = nreset_i & core_v_i & (core_w_i | w_core_slot_free);
    assign w_snoop_ok        = nreset_i & snoop_v_i & w_snoop_slot_free;
    assign w_starved         = (r_starve_cnt == cnt_width_lp'(starve_limit_p));

    // A core write and a snoop read cannot share the macro; the write wins until snoop has waited long enough.
    assign w_core_gnt  = w_core_ok & ~(w_cw & w_snoop_ok & w_starved);
    assign w_snoop_gnt = w_snoop_ok & ~(w_cw & ~w_starved);

    assign core_ready_o  = w_core_gnt;
    assign snoop_ready_o = w_snoop_gnt;

    assign mem_a_v_o    = w_core_gnt;
    assign mem_a_w_o    = core_w_i;
    assign mem_a_addr_o = core_addr_i;
    assign mem_a_mask_o = core_mask_i;
    assign mem_a_data_o = core_data_i;
    assign mem_b_v_o    = w_snoop_gnt;
    assign mem_b_addr_o = snoop_addr_i;

    // Count consecutive cycles a ready-to-go snoop loses to a core write; clear on snoop grant or idle.
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            r_starve_cnt <= '0;
        end else if (!snoop_v_i || w_snoop_gnt) begin
            r_starve_cnt <= '0;
        end else if (w_snoop_ok && w_cw && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Core response slot: track the in-flight read and park unconsumed data in the hold register.
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            r_core_pend   <= 1'b0;
            r_core_hold_v <= 1'b0;
        end else begin
            r_core_pend   <= w_core_gnt & ~core_w_i;
            r_core_hold_v <= core_rsp_v_o & ~core_rsp_yumi_i;
            if (r_core_pend && !core_rsp_yumi_i) begin
                r_core_hold <= mem_a_data_i;
            end
        end
    end

    // Snoop response slot: same scheme as the core slot, fed from macro port B.
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            r_snoop_pend   <= 1'b0;
            r_snoop_hold_v <= 1'b0;
        end else begin
            r_snoop_pend   <= w_snoop_gnt;
            r_snoop_hold_v <= snoop_rsp_v_o & ~snoop_rsp_yumi_i;
            if (r_snoop_pend && !snoop_rsp_yumi_i) begin
                r_snoop_hold <= mem_b_data_i;
            end
        end
    end

    // Catch requesters consuming a response that does not exist, and any write/read overlap on the macro.
    always_ff @(posedge clk_i) begin
        if (nreset_i) begin
            assert (!(core_rsp_yumi_i && !core_rsp_v_o));
            assert (!(snoop_rsp_yumi_i && !snoop_rsp_v_o));
            assert (!(mem_a_v_o && mem_a_w_o && mem_b_v_o));
        end
    end

endmodule

// File: tb/tb_mem_2r1w_port_arbiter.sv
// Bench for mem_2r1w_port_arbiter: behavioural macro plus a queue-based reference model.
// Each cycle compares grants, macro drive and responses against the model, then updates it at the edge.
// Directed scenarios first, then randomized traffic with random response backpressure and resets.
module tb_mem_2r1w_port_arbiter;

    localparam int W     = 32;
    localparam int ELS   = 64;
    localparam int AW    = 6;
    localparam int LIMIT = 4;

    logic          clk_i = 1'b0;
    logic          nreset_i;
    logic          core_v_i, core_w_i;
    logic [AW-1:0] core_addr_i;
    logic [W-1:0]  core_mask_i, core_data_i;
    logic          core_ready_o, core_rsp_v_o;
    logic [W-1:0]  core_rsp_data_o;
    logic          core_rsp_yumi_i;
    logic          snoop_v_i;
    logic [AW-1:0] snoop_addr_i;
    logic          snoop_ready_o, snoop_rsp_v_o;
    logic [W-1:0]  snoop_rsp_data_o;
    logic          snoop_rsp_yumi_i;
    logic          mem_a_v_o, mem_a_w_o;
    logic [AW-1:0] mem_a_addr_o;
    logic [W-1:0]  mem_a_mask_o, mem_a_data_o;
    logic [W-1:0]  mem_a_data_i;
    logic          mem_b_v_o;
    logic [AW-1:0] mem_b_addr_o;
    logic [W-1:0]  mem_b_data_i;

    always #5 clk_i = ~clk_i;

    mem_2r1w_port_arbiter #(.width_p(W), .els_p(ELS), .starve_limit_p(LIMIT)) dut (
        .clk_i(clk_i), .nreset_i(nreset_i),
        .core_v_i(core_v_i), .core_w_i(core_w_i), .core_addr_i(core_addr_i),
        .core_mask_i(core_mask_i), .core_data_i(core_data_i), .core_ready_o(core_ready_o),
        .core_rsp_v_o(core_rsp_v_o), .core_rsp_data_o(core_rsp_data_o), .core_rsp_yumi_i(core_rsp_yumi_i),
        .snoop_v_i(snoop_v_i), .snoop_addr_i(snoop_addr_i), .snoop_ready_o(snoop_ready_o),
        .snoop_rsp_v_o(snoop_rsp_v_o), .snoop_rsp_data_o(snoop_rsp_data_o), .snoop_rsp_yumi_i(snoop_rsp_yumi_i),
        .mem_a_v_o(mem_a_v_o), .mem_a_w_o(mem_a_w_o), .mem_a_addr_o(mem_a_addr_o),
        .mem_a_mask_o(mem_a_mask_o), .mem_a_data_o(mem_a_data_o), .mem_a_data_i(mem_a_data_i),
        .mem_b_v_o(mem_b_v_o), .mem_b_addr_o(mem_b_addr_o), .mem_b_data_i(mem_b_data_i)
    );

    // Behavioural 2R1W masked-write macro with one-cycle read latency.
    logic [W-1:0] macro_mem [ELS];
    always @(posedge clk_i) begin
        if (mem_a_v_o && mem_a_w_o)
            macro_mem[mem_a_addr_o] <= (macro_mem[mem_a_addr_o] & ~mem_a_mask_o) | (mem_a_data_o & mem_a_mask_o);
        if (mem_a_v_o && !mem_a_w_o)
            mem_a_data_i <= macro_mem[mem_a_addr_o];
        if (mem_b_v_o)
            mem_b_data_i <= macro_mem[mem_b_addr_o];
    end

    // Reference model state: memory contents, outstanding responses per port, snoop loss streak.
    logic [W-1:0] ref_mem [ELS];
    logic [W-1:0] core_q[$];
    logic [W-1:0] snoop_q[$];
    int           streak;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations from the most recent cycle, for scenario-level checks.
    logic         obs_core_rdy, obs_snoop_rdy, obs_core_rsp_v, obs_snoop_rsp_v;
    logic [W-1:0] obs_core_rsp_data, obs_snoop_rsp_data;
    int           conflict_seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        core_v_i = 0; core_w_i = 0; core_addr_i = '0; core_mask_i = '0; core_data_i = '0;
        core_rsp_yumi_i = 0; snoop_v_i = 0; snoop_addr_i = '0; snoop_rsp_yumi_i = 0;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit cw, c_ok, s_ok, c_g, s_g, rst, cy, sy;
        logic [AW-1:0] ca, sa;
        logic [W-1:0]  cm, cd;
        bit cwr;
        cw = 0; c_ok = 0; s_ok = 0; c_g = 0; s_g = 0;
        @(negedge clk_i);
        rst = !nreset_i; cwr = core_w_i; ca = core_addr_i; sa = snoop_addr_i;
        cm = core_mask_i; cd = core_data_i; cy = core_rsp_yumi_i; sy = snoop_rsp_yumi_i;
        if (!rst) begin
            cw   = core_v_i && core_w_i;
            c_ok = core_v_i && (core_w_i || core_q.size() == 0 || cy);
            s_ok = snoop_v_i && (snoop_q.size() == 0 || sy);
            if (cw && s_ok) begin
                c_g = (streak < LIMIT);
                s_g = !c_g;
            end else begin
                c_g = c_ok;
                s_g = s_ok;
            end
        end
        chk("core_ready", core_ready_o, c_g);
        chk("snoop_ready", snoop_ready_o, s_g);
        chk("mem_a_v", mem_a_v_o, c_g);
        chk("mem_b_v", mem_b_v_o, s_g);
        chk("a_write_vs_b_read", mem_a_v_o && mem_a_w_o && mem_b_v_o, 0);
        if (c_g) chk("mem_a_addr", {mem_a_w_o, mem_a_addr_o}, {cwr, ca});
        if (s_g) chk("mem_b_addr", mem_b_addr_o, sa);
        chk("core_rsp_v", core_rsp_v_o, !rst && core_q.size() > 0);
        chk("snoop_rsp_v", snoop_rsp_v_o, !rst && snoop_q.size() > 0);
        if (!rst && core_q.size() > 0) chk("core_rsp_data", core_rsp_data_o, core_q[0]);
        if (!rst && snoop_q.size() > 0) chk("snoop_rsp_data", snoop_rsp_data_o, snoop_q[0]);
        if (mem_a_v_o && mem_a_w_o && snoop_v_i) conflict_seen++;
        obs_core_rdy = core_ready_o; obs_snoop_rdy = snoop_ready_o;
        obs_core_rsp_v = core_rsp_v_o; obs_snoop_rsp_v = snoop_rsp_v_o;
        obs_core_rsp_data = core_rsp_data_o; obs_snoop_rsp_data = snoop_rsp_data_o;
        @(posedge clk_i);
        if (rst) begin
            core_q.delete(); snoop_q.delete(); streak = 0;
        end else begin
            if (cy && core_q.size() > 0) void'(core_q.pop_front());
            if (sy && snoop_q.size() > 0) void'(snoop_q.pop_front());
            if (c_g && !cwr) core_q.push_back(ref_mem[ca]);
            if (s_g) snoop_q.push_back(ref_mem[sa]);
            if (c_g && cwr) ref_mem[ca] = (ref_mem[ca] & ~cm) | (cd & cm);
            if (!snoop_v_i || s_g) streak = 0;
            else if (s_ok && cw) streak = (streak + 1 > LIMIT) ? LIMIT : streak + 1;
        end
        #1;
    endtask

    task automatic core_write(input int a, input logic [W-1:0] d, input logic [W-1:0] m);
        core_v_i = 1; core_w_i = 1; core_addr_i = AW'(a); core_data_i = d; core_mask_i = m;
    endtask

    task automatic core_read(input int a);
        core_v_i = 1; core_w_i = 0; core_addr_i = AW'(a);
    endtask

    logic [W-1:0] exp_stream [8];

    initial begin
        streak = 0;
        conflict_seen = 0;
        idle();
        nreset_i = 0;
        cycle();
        cycle();
        chk("reset_core_rsp_v", obs_core_rsp_v, 0);
        chk("reset_snoop_rsp_v", obs_snoop_rsp_v, 0);
        nreset_i = 1;

        // Fill every word with known random contents.
        for (int a = 0; a < ELS; a++) begin
            core_write(a, $urandom, '1);
            cycle();
        end
        idle();

        // Reset while a core read is in flight: no response ever appears.
        core_read(1);
        cycle();
        chk("midflight_granted", obs_core_rdy, 1);
        idle();
        nreset_i = 0;
        cycle();
        chk("midflight_rsp_in_reset", obs_core_rsp_v, 0);
        nreset_i = 1;
        cycle();
        chk("midflight_rsp_after", obs_core_rsp_v, 0);

        // Dual read of the same word.
        core_write(5, 32'hDEADBEEF, '1);
        cycle();
        core_read(5); snoop_v_i = 1; snoop_addr_i = 5;
        cycle();
        chk("dual_core_rdy", obs_core_rdy, 1);
        chk("dual_snoop_rdy", obs_snoop_rdy, 1);
        idle(); core_rsp_yumi_i = 1; snoop_rsp_yumi_i = 1;
        cycle();
        chk("dual_core_data", {obs_core_rsp_v, obs_core_rsp_data}, {1'b1, 32'hDEADBEEF});
        chk("dual_snoop_data", {obs_snoop_rsp_v, obs_snoop_rsp_data}, {1'b1, 32'hDEADBEEF});
        idle();

        // Masked write merges only the enabled byte.
        core_write(3, 32'hFFFFFFFF, '1);
        cycle();
        core_write(3, 32'h0, 32'h0000FF00);
        cycle();
        core_read(3);
        cycle();
        idle(); core_rsp_yumi_i = 1;
        cycle();
        chk("masked_write", obs_core_rsp_data, 32'hFFFF00FF);
        idle();
        cycle();

        // Continuous core writes against a waiting snoop.
        snoop_v_i = 1; snoop_addr_i = 11;
        for (int i = 0; i < LIMIT; i++) begin
            core_write(10, $urandom, '1);
            cycle();
            chk("starve_snoop_denied", obs_snoop_rdy, 0);
            chk("starve_core_wins", obs_core_rdy, 1);
        end
        core_write(10, $urandom, '1);
        cycle();
        chk("starve_snoop_forced", obs_snoop_rdy, 1);
        chk("starve_core_blocked", obs_core_rdy, 0);
        snoop_v_i = 0; snoop_rsp_yumi_i = 1;
        core_write(10, $urandom, '1);
        cycle();
        chk("starve_snoop_rsp", obs_snoop_rsp_v, 1);
        snoop_rsp_yumi_i = 0; snoop_v_i = 1;
        core_write(10, $urandom, '1);
        cycle();
        chk("starve_cnt_cleared", obs_snoop_rdy, 0);
        idle();
        cycle();

        // Snoop response held under backpressure while the word is overwritten.
        snoop_v_i = 1; snoop_addr_i = 5;
        cycle();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) core_write(5, 32'h1, '1);
            else begin core_v_i = 0; core_w_i = 0; end
            cycle();
            chk("bp_hold_data", {obs_snoop_rsp_v, obs_snoop_rsp_data}, {1'b1, 32'hDEADBEEF});
            chk("bp_snoop_blocked", obs_snoop_rdy, 0);
        end
        idle(); snoop_rsp_yumi_i = 1;
        cycle();
        chk("bp_yumi_data", obs_snoop_rsp_data, 32'hDEADBEEF);
        idle();
        cycle();
        chk("bp_rsp_cleared", obs_snoop_rsp_v, 0);
        snoop_v_i = 1; snoop_addr_i = 5;
        cycle();
        idle(); snoop_rsp_yumi_i = 1;
        cycle();
        chk("bp_new_value", obs_snoop_rsp_data, 32'h1);
        idle();
        cycle();

        // Back-to-back core reads stream one word per cycle.
        for (int i = 0; i < 8; i++) exp_stream[i] = ref_mem[i];
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) core_read(i);
            else begin core_v_i = 0; end
            core_rsp_yumi_i = (i > 0);
            cycle();
            if (i < 8) chk("stream_ready", obs_core_rdy, 1);
            if (i > 0) chk("stream_data", {obs_core_rsp_v, obs_core_rsp_data}, {1'b1, exp_stream[i-1]});
        end
        idle();
        cycle();
        chk("stream_done", obs_core_rsp_v, 0);

        // Randomized traffic with random backpressure and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            nreset_i = ($urandom_range(0, 199) != 0);
            core_v_i = ($urandom_range(0, 3) != 0);
            core_w_i = $urandom_range(0, 1);
            core_addr_i = AW'($urandom_range(0, 7));
            core_mask_i = $urandom;
            core_data_i = $urandom;
            snoop_v_i = ($urandom_range(0, 3) != 0);
            snoop_addr_i = AW'($urandom_range(0, 7));
            core_rsp_yumi_i = nreset_i && core_q.size() > 0 && ($urandom_range(0, 3) != 0);
            snoop_rsp_yumi_i = nreset_i && snoop_q.size() > 0 && ($urandom_range(0, 2) != 0);
            cycle();
        end
        nreset_i = 1;
        idle();
        cycle();
        chk("random_had_conflicts", conflict_seen > 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
